// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch (I, read-only)
// and load/store (D, read/write). One transaction is outstanding at a time.
// D has priority, and a starvation counter guarantees that fetch makes progress.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int unsigned CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = D side owns the transaction
  logic                drop_q, drop_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [3:0]          m_wstrb_q, m_wstrb_d;
  logic                i_rvalid_q, i_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic starve_hit;
  logic grant_d;
  logic grant_i;

  // Arbitration: D wins unless fetch has waited STARVE_MAX consecutive D grants
  always_comb begin
    starve_hit = (starve_cnt_q == CNT_W'(STARVE_MAX));
    grant_d    = (state_q == S_IDLE) && d_req && !(i_req && starve_hit);
    grant_i    = (state_q == S_IDLE) && !grant_d && i_req;
  end

  // Accepts are combinational; forced low during reset so all outputs read 0
  assign i_ready = grant_i && !rst;
  assign d_ready = grant_d && !rst;

  // Next-state, command latch, starvation and response logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    drop_d       = drop_q;
    starve_cnt_d = starve_cnt_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_wstrb_d    = m_wstrb_q;
    i_rvalid_d   = 1'b0;
    d_rvalid_d   = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (!i_req) begin
          starve_cnt_d = '0;
        end
        if (grant_d) begin
          owner_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_wstrb_d = d_wstrb;
          m_req_d   = 1'b1;
          state_d   = S_ISSUE;
          if (i_req && !starve_hit) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end else if (grant_i) begin
          owner_d      = 1'b0;
          m_we_d       = 1'b0;
          m_addr_d     = i_addr;
          m_wdata_d    = '0;
          m_wstrb_d    = 4'h0;
          m_req_d      = 1'b1;
          state_d      = S_ISSUE;
          starve_cnt_d = '0;
        end
      end

      S_ISSUE: begin
        if (!owner_q && i_flush) begin
          drop_d = 1'b1;
        end
        if (m_ready) begin
          m_req_d = 1'b0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (!owner_q && i_flush) begin
          drop_d = 1'b1;
        end
        if (m_rvalid) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
          if (owner_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = m_we_q ? '0 : m_rdata;
          end else if (!(drop_q || i_flush)) begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = m_rdata;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      drop_q       <= 1'b0;
      starve_cnt_q <= '0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_wstrb_q    <= 4'h0;
      i_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      drop_q       <= drop_d;
      starve_cnt_q <= starve_cnt_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_wstrb_q    <= m_wstrb_d;
      i_rvalid_q   <= i_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_wstrb  = m_wstrb_q;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change 1ns after a rising edge.
// Registered outputs are sampled after that edge, and combinational readies
// are sampled mid-cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_flush, i_ready, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ready, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        m_req, m_we, m_ready, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_ready(i_ready),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    i_req = 0; i_addr = 0; i_flush = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    m_ready = 1; m_rvalid = 0; m_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mreq", m_req, 0);
    chk("rst_state", dut.state_q, 0);
    chk("rst_cnt", dut.starve_cnt_q, 0);
    chk("rst_rv", {i_rvalid, d_rvalid, i_ready, d_ready}, 0);
    rst = 1'b0;
    tick();

    // 1: single fetch, minimum latency
    i_req = 1; i_addr = 32'h10;
    #3 chk("t1_irdy", {i_ready, d_ready}, 2'b10);
    tick(); i_req = 0;
    chk("t1_mreq", {m_req, m_we}, 2'b10);
    chk("t1_maddr", m_addr, 32'h10);
    tick(); m_rvalid = 1; m_rdata = 32'hDEADBEEF;
    chk("t1_c2_rv", i_rvalid, 0);
    tick(); m_rvalid = 0;
    chk("t1_c3_rv", {i_rvalid, d_rvalid}, 2'b10);
    chk("t1_rdata", i_rdata, 32'hDEADBEEF);
    tick();
    chk("t1_c4_rv", i_rvalid, 0);

    // 2: simultaneous requests, D write first
    i_req = 1; i_addr = 32'h40;
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678; d_wstrb = 4'hF;
    #3 chk("t2_rdy", {i_ready, d_ready}, 2'b01);
    tick(); d_req = 0;
    chk("t2_cmd", {m_req, m_we, m_wstrb}, 6'b11_1111);
    chk("t2_addr", m_addr, 32'h20);
    chk("t2_wdata", m_wdata, 32'h12345678);
    tick(); m_rvalid = 1; m_rdata = 32'h55555555;
    tick(); m_rvalid = 0;
    chk("t2_drv", {d_rvalid, i_rvalid}, 2'b10);
    chk("t2_drdata", d_rdata, 0);
    #3 chk("t2_irdy", i_ready, 1);
    tick(); i_req = 0;
    chk("t2_icmd", {m_req, m_we}, 2'b10);
    chk("t2_iaddr", m_addr, 32'h40);
    tick(); m_rvalid = 1; m_rdata = 32'hA5A5A5A5;
    tick(); m_rvalid = 0;
    chk("t2_irv", {i_rvalid, d_rvalid}, 2'b10);
    chk("t2_irdata", i_rdata, 32'hA5A5A5A5);

    // 3: starvation limit forces fetch after four D grants
    i_req = 1; i_addr = 32'h200;
    d_req = 1; d_we = 0; d_addr = 32'h100; d_wdata = 0; d_wstrb = 0;
    for (int k = 0; k < 5; k++) begin
      #3 chk("t3_rdy", {i_ready, d_ready}, (k < 4) ? 2'b01 : 2'b10);
      if (k == 4) chk("t3_cnt_max", dut.starve_cnt_q, 4);
      tick();
      if (k == 4) begin i_req = 0; d_req = 0; end
      chk("t3_addr", m_addr, (k < 4) ? 32'h100 : 32'h200);
      tick(); m_rvalid = 1; m_rdata = 32'h1000 + k;
      tick(); m_rvalid = 0;
      chk("t3_rv", {d_rvalid, i_rvalid}, (k < 4) ? 2'b10 : 2'b01);
      if (k < 4) chk("t3_drdata", d_rdata, 32'h1000 + k);
      else       chk("t3_irdata", i_rdata, 32'h1004);
    end
    chk("t3_cnt_clr", dut.starve_cnt_q, 0);

    // 4: flush while waiting drops the fetch response
    i_req = 1; i_addr = 32'h80;
    tick(); i_req = 0;
    tick(); i_flush = 1;
    tick(); i_flush = 0; m_rvalid = 1; m_rdata = 32'hCAFE0000;
    tick(); m_rvalid = 0;
    chk("t4_norv", i_rvalid, 0);
    chk("t4_hold", i_rdata, 32'h1004);
    chk("t4_state", dut.state_q, 0);
    i_req = 1; i_addr = 32'h84;
    #3 chk("t4_irdy", i_ready, 1);
    tick(); i_req = 0;
    tick(); m_rvalid = 1; m_rdata = 32'h11112222;
    tick(); m_rvalid = 0;
    chk("t4_rv", i_rvalid, 1);
    chk("t4_rdata", i_rdata, 32'h11112222);
    // flush in the same cycle as the response also suppresses it
    i_req = 1; i_addr = 32'h88;
    tick(); i_req = 0;
    tick(); i_flush = 1; m_rvalid = 1; m_rdata = 32'h00000BAD;
    tick(); i_flush = 0; m_rvalid = 0;
    chk("t4b_norv", i_rvalid, 0);
    chk("t4b_hold", i_rdata, 32'h11112222);

    // 5: memory stalls five cycles in ISSUE
    m_ready = 0;
    d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'h0BADF00D; d_wstrb = 4'h3;
    tick();
    i_req = 1; i_addr = 32'h300; d_addr = 32'h99; d_wdata = 0; d_wstrb = 4'hC;
    for (int j = 0; j < 5; j++) begin
      #3;
      chk("t5_mreq", {m_req, m_we, m_wstrb}, 6'b11_0011);
      chk("t5_addr", m_addr, 32'h30);
      chk("t5_wdata", m_wdata, 32'h0BADF00D);
      chk("t5_rdy", {i_ready, d_ready}, 0);
      tick();
    end
    m_ready = 1; i_req = 0; d_req = 0;
    tick(); m_rvalid = 1; m_rdata = 32'hFFFF;
    tick(); m_rvalid = 0;
    chk("t5_drv", d_rvalid, 1);
    chk("t5_drdata", d_rdata, 0);

    // 6: reset during WAIT aborts, stray response is ignored
    i_req = 1; i_addr = 32'h50;
    tick(); i_req = 0;
    tick(); rst = 1; i_req = 1;
    #1;
    chk("t6_state", dut.state_q, 0);
    chk("t6_mreq", {m_req, m_we, i_ready, d_ready, i_rvalid, d_rvalid}, 0);
    chk("t6_maddr", m_addr, 0);
    chk("t6_rdata", {i_rdata, d_rdata}, 0);
    tick(); rst = 0; i_req = 0; m_rvalid = 1; m_rdata = 32'h77;
    tick(); m_rvalid = 0;
    chk("t6_stray", {i_rvalid, d_rvalid}, 0);
    chk("t6_stray_rd", i_rdata, 0);
    chk("t6_idle", dut.state_q, 0);
    i_req = 1; i_addr = 32'h60;
    #3 chk("t6_irdy", i_ready, 1);
    tick(); i_req = 0;
    chk("t6_addr", m_addr, 32'h60);
    tick(); m_rvalid = 1; m_rdata = 32'h600D600D;
    tick(); m_rvalid = 0;
    chk("t6_rv", i_rvalid, 1);
    chk("t6_rd", i_rdata, 32'h600D600D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
